// File: rtl/irq_source_unit.sv
// irq_source_unit: synchronises and latches interrupt sources, holds MSIP and the machine timer, and drives mip_in
module irq_source_unit #(
    parameter int N_SRC   = 8,
    parameter int TIMER_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             reg_we,
    input  logic             reg_re,
    input  logic [2:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    input  logic             ack_valid,
    input  logic [4:0]       ack_code,
    output logic [31:0]      mip_in
);
    logic [N_SRC-1:0] s1, s2, s2_d, enable, edge_cfg, pending, pending_nxt;
    logic [N_SRC-1:0] src, ext_mask, ack_mask, w1c_mask;
    logic [TIMER_W-1:0] mtime, mtimecmp, prescale, pc, mtime_nxt, pc_nxt;
    logic msip, timer_hit, tick;
    logic wr_en, wr_edge, wr_pend, wr_msip, wr_mtime, wr_cmp, wr_pre;
    logic [31:0] rd_val;

    assign wr_en    = reg_we && reg_addr == 3'd0;
    assign wr_edge  = reg_we && reg_addr == 3'd1;
    assign wr_pend  = reg_we && reg_addr == 3'd2;
    assign wr_msip  = reg_we && reg_addr == 3'd3;
    assign wr_mtime = reg_we && reg_addr == 3'd4;
    assign wr_cmp   = reg_we && reg_addr == 3'd5;
    assign wr_pre   = reg_we && reg_addr == 3'd6;

    assign timer_hit = mtime >= mtimecmp;
    assign tick      = pc == prescale;
    assign mtime_nxt = wr_mtime ? reg_wdata[TIMER_W-1:0] : tick ? mtime + TIMER_W'(1) : mtime;
    assign pc_nxt    = (wr_mtime || wr_pre || tick) ? '0 : pc + TIMER_W'(1);

    // Sources 3 and 7 are internal (MSIP, timer); only the others latch pending.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ext_mask[i] = i != 3 && i != 7;
            src[i]      = i == 3 ? msip : i == 7 ? timer_hit : pending[i];
        end
    end

    assign ack_mask    = ack_valid && {27'd0, ack_code} < 32'(N_SRC) ? N_SRC'(1) << ack_code : '0;
    assign w1c_mask    = wr_pend ? reg_wdata[N_SRC-1:0] : '0;
    // A fresh edge is ORed in after the clear so it wins over a same-cycle clear.
    assign pending_nxt = ext_mask & ((edge_cfg & ((pending & ~(w1c_mask | ack_mask)) | (s2 & ~s2_d)))
                                     | (~edge_cfg & s2));

    always_comb begin
        case (reg_addr)
            3'd0:    rd_val = 32'(enable);
            3'd1:    rd_val = 32'(edge_cfg);
            3'd2:    rd_val = 32'(src);
            3'd3:    rd_val = {31'd0, msip};
            3'd4:    rd_val = 32'(mtime);
            3'd5:    rd_val = 32'(mtimecmp);
            3'd6:    rd_val = 32'(prescale);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= '0;
            s2        <= '0;
            s2_d      <= '0;
            pending   <= '0;
            mip_in    <= '0;
            reg_rdata <= '0;
        end else begin
            s1      <= irq_src;
            s2      <= s1;
            s2_d    <= s2;
            pending <= pending_nxt;
            mip_in  <= 32'(src & enable);
            if (reg_re) reg_rdata <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= '0;
            edge_cfg <= '0;
            msip     <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            prescale <= '0;
            pc       <= '0;
        end else begin
            if (wr_en) enable <= reg_wdata[N_SRC-1:0];
            if (wr_edge) edge_cfg <= reg_wdata[N_SRC-1:0];
            if (wr_msip) msip <= reg_wdata[0];
            if (wr_cmp) mtimecmp <= reg_wdata[TIMER_W-1:0];
            if (wr_pre) prescale <= reg_wdata[TIMER_W-1:0];
            mtime <= mtime_nxt;
            pc    <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_irq_source_unit.sv
// tb_irq_source_unit: directed checks of irq_source_unit with hand-computed expectations
module tb_irq_source_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic        reg_we = 1'b0;
    logic        reg_re = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        ack_valid = 1'b0;
    logic [4:0]  ack_code = '0;
    logic [31:0] mip_in;
    logic [31:0] d;
    int checks = 0;
    int errors = 0;

    irq_source_unit dut (
        .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .reg_we(reg_we), .reg_re(reg_re),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .ack_valid(ack_valid), .ack_code(ack_code), .mip_in(mip_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        reg_addr = a;
        reg_wdata = v;
        reg_we = 1'b1;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        reg_addr = a;
        reg_re = 1'b1;
        tick();
        reg_re = 1'b0;
        v = reg_rdata;
    endtask

    task automatic ack(input logic [4:0] c);
        ack_code = c;
        ack_valid = 1'b1;
        tick();
        ack_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end

    initial begin
        tick(); tick(); tick();
        check("rst_mip", mip_in, 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);
        reset_n = 1'b1;
        rd(3'd5, d); check("rst_mtimecmp", d, 32'hFFFF_FFFF);
        rd(3'd0, d); check("rst_enable", d, 32'h0);
        wr(3'd0, 32'hFF);
        rd(3'd0, d); check("enable_rb", d, 32'h0000_00FF);
        rd(3'd1, d); check("rst_edge", d, 32'h0);
        wr(3'd7, 32'hDEAD_BEEF);
        rd(3'd7, d); check("addr7_zero", d, 32'h0);

        // edge source 1: latency, disable/enable, ack, W1C
        wr(3'd1, 32'h2);
        irq_src[1] = 1'b1; tick();
        irq_src[1] = 1'b0; tick();
        tick(); check("edge_n2", mip_in, 32'h0);
        tick(); check("edge_n3", mip_in, 32'h2);
        wr(3'd0, 32'hFD); check("dis_same", mip_in, 32'h2);
        tick(); check("dis_drop", mip_in, 32'h0);
        rd(3'd2, d); check("dis_pend_kept", d, 32'h2);
        wr(3'd0, 32'hFF);
        tick(); check("reenable", mip_in, 32'h2);
        ack(5'd1); check("ack_same", mip_in, 32'h2);
        tick(); check("ack_clear", mip_in, 32'h0);
        irq_src[1] = 1'b1; tick();
        irq_src[1] = 1'b0; tick(); tick(); tick();
        check("edge_again", mip_in, 32'h2);
        ack(5'd9); tick(); check("ack_oob", mip_in, 32'h2);
        wr(3'd2, 32'h2);
        tick(); check("w1c_clear", mip_in, 32'h0);

        // level source 0
        irq_src[0] = 1'b1;
        tick(); tick(); tick(); tick();
        check("lvl_on", mip_in, 32'h1);
        ack(5'd0); tick(); check("lvl_ack", mip_in, 32'h1);
        wr(3'd2, 32'h1); tick(); check("lvl_w1c", mip_in, 32'h1);
        irq_src[0] = 1'b0;
        tick(); tick(); tick(); check("lvl_n2", mip_in, 32'h1);
        tick(); check("lvl_n3", mip_in, 32'h0);

        // edge source 2: set coincides with ack
        wr(3'd1, 32'h6);
        irq_src[2] = 1'b1; tick();
        irq_src[2] = 1'b0; tick(); tick(); tick();
        check("e2_first", mip_in, 32'h4);
        irq_src[2] = 1'b1; tick();
        irq_src[2] = 1'b0; tick();
        ack(5'd2); check("e2_set_wins_a", mip_in, 32'h4);
        tick(); check("e2_set_wins_b", mip_in, 32'h4);
        rd(3'd2, d); check("e2_pending", d, 32'h4);
        ack(5'd2); tick(); check("e2_ack_clear", mip_in, 32'h0);

        // MSIP
        wr(3'd0, 32'h08);
        wr(3'd3, 32'h1); check("msip_same", mip_in, 32'h0);
        tick(); check("msip_on", mip_in, 32'h8);
        ack(5'd3); tick(); check("msip_ack", mip_in, 32'h8);
        rd(3'd3, d); check("msip_rb", d, 32'h1);
        wr(3'd3, 32'h0); tick(); check("msip_off", mip_in, 32'h0);

        // timer with prescale 3: MTIME reaches 5 at write(PRESCALE)+21
        wr(3'd0, 32'h80);
        wr(3'd6, 32'd3);
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd5);
        for (int i = 0; i < 19; i++) tick();
        check("tmr_early", mip_in, 32'h0);
        tick(); check("tmr_hit", mip_in, 32'h80);
        rd(3'd4, d); check("tmr_mtime", d, 32'd5);
        wr(3'd5, 32'hFFFF_FFFF); check("cmp_same", mip_in, 32'h80);
        tick(); check("cmp_drop", mip_in, 32'h0);

        // wrap and write-beats-increment at prescale 0
        wr(3'd6, 32'd0);
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd4, d); check("wrap_pre", d, 32'hFFFF_FFFF);
        rd(3'd4, d); check("wrap_zero", d, 32'h0);
        wr(3'd4, 32'h1234);
        rd(3'd4, d); check("wr_beats_inc", d, 32'h1234);
        rd(3'd4, d); check("inc_after_wr", d, 32'h1235);
        rd(3'd6, d); check("prescale_rb", d, 32'h0);

        // asynchronous reset mid-operation
        wr(3'd0, 32'hFF);
        wr(3'd3, 32'h1);
        rd(3'd0, d); check("pre_rst_rd", d, 32'hFF);
        check("pre_rst_mip", mip_in, 32'h8);
        reset_n = 1'b0;
        #1;
        check("arst_mip", mip_in, 32'h0);
        check("arst_rdata", reg_rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        rd(3'd3, d); check("arst_msip", d, 32'h0);
        rd(3'd5, d); check("arst_cmp", d, 32'hFFFF_FFFF);
        rd(3'd0, d); check("arst_enable", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
